// File: rtl/alu_wide_sequencer.sv
// Wide-operand sequencer: runs NUM_WORDS x 32-bit integer ops on the shared
// 32-bit combinational ALU one word per cycle, least-significant word first.
// Carry/borrow is chained through ADC/SBC. The result and a combined
// {N,Z,C,V} status are returned over a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   req_valid/req_ready      request handshake; req_op/req_a/req_b payload
//   flush                    synchronous abort of any op in flight
//   resp_valid/resp_ready    response handshake; res_data/res_status/res_write
//   alu_val1/alu_val2        ALU operands for the current word
//   alu_exe_cmd/alu_carry_in ALU command and chained carry/borrow
//   alu_result/alu_status    ALU result and {N,Z,C,V}, same cycle
module alu_wide_sequencer #(
    parameter int unsigned NUM_WORDS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [32*NUM_WORDS-1:0]   req_a,
    input  logic [32*NUM_WORDS-1:0]   req_b,
    input  logic                      flush,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [32*NUM_WORDS-1:0]   res_data,
    output logic [3:0]                res_status,
    output logic                      res_write,
    output logic [31:0]               alu_val1,
    output logic [31:0]               alu_val2,
    output logic [3:0]                alu_exe_cmd,
    output logic                      alu_carry_in,
    input  logic [31:0]               alu_result,
    input  logic [3:0]                alu_status
);

    localparam int unsigned W     = 32 * NUM_WORDS;
    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_MVN = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_ORR = 3'b101;
    localparam logic [2:0] OP_EOR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    localparam logic [3:0] CMD_IDLE = 4'b0000;
    localparam logic [3:0] CMD_MOV  = 4'b0001;
    localparam logic [3:0] CMD_ADD  = 4'b0010;
    localparam logic [3:0] CMD_ADC  = 4'b0011;
    localparam logic [3:0] CMD_SUB  = 4'b0100;
    localparam logic [3:0] CMD_SBC  = 4'b0101;
    localparam logic [3:0] CMD_AND  = 4'b0110;
    localparam logic [3:0] CMD_ORR  = 4'b0111;
    localparam logic [3:0] CMD_EOR  = 4'b1000;
    localparam logic [3:0] CMD_MVN  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               z_acc_q, z_acc_d;
    logic [2:0]         op_q, op_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       res_data_q, res_data_d;
    logic [3:0]         res_status_q, res_status_d;
    logic               res_write_q, res_write_d;

    logic               first_word;

    assign first_word = (idx_q == '0);

    // Handshake flags decode straight from the state register.
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign res_data   = res_data_q;
    assign res_status = res_status_q;
    assign res_write  = res_write_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            z_acc_q      <= 1'b0;
            op_q         <= OP_MOV;
            a_q          <= '0;
            b_q          <= '0;
            res_data_q   <= '0;
            res_status_q <= 4'b0000;
            res_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            z_acc_q      <= z_acc_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
            res_write_q  <= res_write_d;
        end
    end

    // Next-state, datapath update and ALU drive.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        z_acc_d      = z_acc_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
        res_write_d  = res_write_q;
        alu_val1     = 32'd0;
        alu_val2     = 32'd0;
        alu_exe_cmd  = CMD_IDLE;
        alu_carry_in = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    z_acc_d = 1'b1;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_val1     = a_q[{idx_q, 5'b00000} +: 32];
                alu_val2     = b_q[{idx_q, 5'b00000} +: 32];
                alu_carry_in = first_word ? 1'b0 : carry_q;
                unique case (op_q)
                    OP_MOV:         alu_exe_cmd = CMD_MOV;
                    OP_MVN:         alu_exe_cmd = CMD_MVN;
                    OP_ADD:         alu_exe_cmd = first_word ? CMD_ADD : CMD_ADC;
                    OP_SUB, OP_CMP: alu_exe_cmd = first_word ? CMD_SUB : CMD_SBC;
                    OP_AND:         alu_exe_cmd = CMD_AND;
                    OP_ORR:         alu_exe_cmd = CMD_ORR;
                    OP_EOR:         alu_exe_cmd = CMD_EOR;
                    default:        alu_exe_cmd = CMD_IDLE;
                endcase

                if (flush) begin
                    // Abort leaves result registers untouched; no response.
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    res_data_d[{idx_q, 5'b00000} +: 32] = alu_result;
                    carry_d = alu_status[1];
                    z_acc_d = z_acc_q & alu_status[2];
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        // C and V come from the top word; Z is the running AND.
                        res_status_d = {alu_status[3], z_acc_q & alu_status[2],
                                        alu_status[1], alu_status[0]};
                        res_write_d  = (op_q != OP_CMP);
                        idx_d        = '0;
                        state_d      = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // flush and resp_ready both return to IDLE; no accept this cycle.
                if (flush || resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Self-checking bench for alu_wide_sequencer (NUM_WORDS = 2). A bench-side
// 32-bit ALU answers the DUT's ALU port; a whole-operand arithmetic model
// supplies the expected wide result and flags, and a negedge compare process
// checks every cycle a response is presented.
module tb_alu_wide_sequencer;

    localparam int unsigned NW = 2;
    localparam int unsigned W  = 32 * NW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          flush;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  res_data;
    logic [3:0]    res_status;
    logic          res_write;
    logic [31:0]   alu_val1;
    logic [31:0]   alu_val2;
    logic [3:0]    alu_exe_cmd;
    logic          alu_carry_in;
    logic [31:0]   alu_result;
    logic [3:0]    alu_status;

    int vectors     = 0;
    int miscompares = 0;

    logic          exp_pending = 1'b0;
    logic [W-1:0]  exp_data;
    logic [3:0]    exp_status;
    logic          exp_write;

    logic [2:0]    nx_op;
    logic [W-1:0]  nx_a;
    logic [W-1:0]  nx_b;

    always #5 clk = ~clk;

    alu_wide_sequencer #(.NUM_WORDS(NW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .flush        (flush),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .res_data     (res_data),
        .res_status   (res_status),
        .res_write    (res_write),
        .alu_val1     (alu_val1),
        .alu_val2     (alu_val2),
        .alu_exe_cmd  (alu_exe_cmd),
        .alu_carry_in (alu_carry_in),
        .alu_result   (alu_result),
        .alu_status   (alu_status)
    );

    // Shared 32-bit ALU as seen by the sequencer: {N,Z,C,V, result}.
    function automatic logic [35:0] alu_fn(input logic [3:0] cmd, input logic [31:0] x,
                                           input logic [31:0] y, input logic ci);
        logic [32:0] t;
        logic [31:0] r;
        logic        c;
        logic        v;
        t = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
        case (cmd)
            4'b0001: r = y;
            4'b1001: r = ~y;
            4'b0010, 4'b0011: begin
                t = {1'b0, x} + {1'b0, y} + 33'(ci & cmd[0]);
                r = t[31:0]; c = t[32];
                v = (x[31] == y[31]) && (r[31] != x[31]);
            end
            4'b0100, 4'b0101: begin
                t = {1'b0, x} - {1'b0, y} - 33'(ci & cmd[0]);
                r = t[31:0]; c = t[32];
                v = (x[31] != y[31]) && (r[31] != x[31]);
            end
            4'b0110: r = x & y;
            4'b0111: r = x | y;
            4'b1000: r = x ^ y;
            default: r = 32'd0;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    assign {alu_status, alu_result} = alu_fn(alu_exe_cmd, alu_val1, alu_val2, alu_carry_in);

    // Whole-operand reference: result and {N,Z,C,V} from plain W-bit arithmetic.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [3:0] st);
        logic [W:0] t;
        logic       c;
        logic       v;
        c = 1'b0; v = 1'b0; r = '0;
        case (op)
            3'b000: r = b;
            3'b001: r = ~b;
            3'b010: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[W-1:0]; c = t[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b011, 3'b111: begin
                r = a - b; c = (a < b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            default: r = a ^ b;
        endcase
        st = {r[W-1], (r == '0), c, v};
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle a response is presented it must match the model.
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            chk("resp_expected", 64'(exp_pending), 64'(1));
            if (exp_pending) begin
                chk("model_data",   64'(res_data),   64'(exp_data));
                chk("model_status", 64'(res_status), 64'(exp_status));
                chk("model_write",  64'(res_write),  64'(exp_write));
            end
        end
    end

    task automatic chk_idle_drive(input string tag);
        chk({tag, "_alu_cmd"},  64'(alu_exe_cmd),  64'(0));
        chk({tag, "_alu_v1"},   64'(alu_val1),     64'(0));
        chk({tag, "_alu_v2"},   64'(alu_val2),     64'(0));
        chk({tag, "_alu_cin"},  64'(alu_carry_in), 64'(0));
    endtask

    // Present a request, arm the model, and return #1 after the accepting edge.
    task automatic accept(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        model(op, a, b, exp_data, exp_status);
        exp_write   = (op != 3'b111);
        exp_pending = 1'b1;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        chk("ready_before_accept", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ready_in_exec", 64'(req_ready), 64'(0));
        chk("valid_edge1",   64'(resp_valid), 64'(0));
    endtask

    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] c0, input logic [3:0] c1, input logic cin1,
                         input logic [W-1:0] lit_d, input logic [3:0] lit_s, input logic lit_w,
                         input int hold, input bit bp);
        accept(op, a, b);
        chk({tag, "_cmd0"}, 64'(alu_exe_cmd),  64'(c0));
        chk({tag, "_cin0"}, 64'(alu_carry_in), 64'(0));
        chk({tag, "_v1_0"}, 64'(alu_val1),     64'(a[31:0]));
        chk({tag, "_v2_0"}, 64'(alu_val2),     64'(b[31:0]));
        @(posedge clk); #1;
        chk({tag, "_cmd1"}, 64'(alu_exe_cmd),  64'(c1));
        chk({tag, "_cin1"}, 64'(alu_carry_in), 64'(cin1));
        chk({tag, "_v1_1"}, 64'(alu_val1),     64'(a[63:32]));
        chk({tag, "_v2_1"}, 64'(alu_val2),     64'(b[63:32]));
        chk({tag, "_noresp_early"}, 64'(resp_valid), 64'(0));
        @(posedge clk); #1;
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(1));
        chk({tag, "_data"},       64'(res_data),   64'(lit_d));
        chk({tag, "_status"},     64'(res_status), 64'(lit_s));
        chk({tag, "_write"},      64'(res_write),  64'(lit_w));
        chk_idle_drive({tag, "_done"});
        if (bp) begin
            req_op = nx_op; req_a = nx_a; req_b = nx_b; req_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(resp_valid), 64'(1));
            chk({tag, "_hold_ready"}, 64'(req_ready),  64'(0));
            chk({tag, "_hold_data"},  64'(res_data),   64'(lit_d));
            chk({tag, "_hold_stat"},  64'(res_status), 64'(lit_s));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready  = 1'b0;
        exp_pending = 1'b0;
        chk({tag, "_after_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, "_after_ready"}, 64'(req_ready),  64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = 3'b000; req_a = '0; req_b = '0;
        flush = 1'b0; resp_ready = 1'b0;
        nx_op = 3'b000; nx_a = '0; nx_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready",  64'(req_ready),  64'(1));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_data",       64'(res_data),   64'(0));
        chk("rst_status",     64'(res_status), 64'(0));
        chk("rst_write",      64'(res_write),  64'(0));
        chk_idle_drive("rst");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        do_op("add_carry", 3'b010, 64'h00000000_FFFFFFFF, 64'h00000000_00000001,
              4'b0010, 4'b0011, 1'b1, 64'h00000001_00000000, 4'b0000, 1'b1, 0, 1'b0);
        do_op("sub_borrow", 3'b011, 64'h0, 64'h1,
              4'b0100, 4'b0101, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 4'b1010, 1'b1, 0, 1'b0);
        do_op("cmp_ovf", 3'b111, 64'h80000000_00000000, 64'h1,
              4'b0100, 4'b0101, 1'b1, 64'h7FFFFFFF_FFFFFFFF, 4'b0001, 1'b0, 0, 1'b0);
        do_op("eor_self", 3'b110, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0,
              4'b1000, 4'b1000, 1'b0, 64'h0, 4'b0100, 1'b1, 0, 1'b0);
        do_op("and_zacc", 3'b100, 64'hFFFFFFFF_0000000F, 64'h00000000_00000001,
              4'b0110, 4'b0110, 1'b0, 64'h00000000_00000001, 4'b0000, 1'b1, 0, 1'b0);
        do_op("add_ovf", 3'b010, 64'h7FFFFFFF_FFFFFFFF, 64'h1,
              4'b0010, 4'b0011, 1'b1, 64'h80000000_00000000, 4'b1001, 1'b1, 0, 1'b0);
        do_op("mvn", 3'b001, 64'hDEAD_BEEF, 64'h00000000_FFFFFFFF,
              4'b1001, 4'b1001, 1'b0, 64'hFFFFFFFF_00000000, 4'b1000, 1'b1, 0, 1'b0);

        // Backpressure: response held 5 cycles with a second request waiting.
        nx_op = 3'b101; nx_a = 64'hF0F0_0000_0000_00FF; nx_b = 64'h0F0F_0000_0000_FF00;
        do_op("orr_bp", 3'b101, 64'hA5A5A5A5_00000000, 64'h00000000_5A5A5A5A,
              4'b0111, 4'b0111, 1'b0, 64'hA5A5A5A5_5A5A5A5A, 4'b1000, 1'b1, 5, 1'b1);
        do_op("orr_next", 3'b101, 64'hF0F0_0000_0000_00FF, 64'h0F0F_0000_0000_FF00,
              4'b0111, 4'b0111, 1'b0, 64'hFFFF_0000_0000_FFFF, 4'b1000, 1'b1, 0, 1'b0);
        do_op("mov", 3'b000, 64'h1111_2222_3333_4444, 64'h0123_4567_89AB_CDEF,
              4'b0001, 4'b0001, 1'b0, 64'h0123_4567_89AB_CDEF, 4'b0000, 1'b1, 0, 1'b0);

        // flush in IDLE blocks acceptance.
        req_op = 3'b010; req_a = 64'h5; req_b = 64'h6; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_idle_ready", 64'(req_ready), 64'(1));
        chk_idle_drive("flush_idle");

        // flush in EXEC: no response appears.
        accept(3'b010, 64'h7, 64'h8);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; exp_pending = 1'b0;
        chk("flush_exec_valid", 64'(resp_valid), 64'(0));
        chk("flush_exec_ready", 64'(req_ready),  64'(1));
        chk_idle_drive("flush_exec");
        repeat (3) @(posedge clk);
        #1;
        chk("flush_exec_noresp", 64'(resp_valid), 64'(0));

        // flush in DONE, with resp_ready also high.
        accept(3'b010, 64'h00000002_00000003, 64'h00000004_00000005);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("flush_done_pre", 64'(resp_valid), 64'(1));
        flush = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; resp_ready = 1'b0; exp_pending = 1'b0;
        chk("flush_done_valid", 64'(resp_valid), 64'(0));
        chk("flush_done_ready", 64'(req_ready),  64'(1));

        // Async reset mid-EXEC clears the held result from the previous op.
        accept(3'b011, 64'h9, 64'h3);
        exp_pending = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_req_ready",  64'(req_ready),  64'(1));
        chk("arst_resp_valid", 64'(resp_valid), 64'(0));
        chk("arst_data",       64'(res_data),   64'(0));
        chk("arst_status",     64'(res_status), 64'(0));
        chk("arst_write",      64'(res_write),  64'(0));
        chk_idle_drive("arst");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("arst_still_idle", 64'(req_ready), 64'(1));

        do_op("add_after", 3'b010, 64'h00000001_80000000, 64'h00000002_80000000,
              4'b0010, 4'b0011, 1'b1, 64'h00000004_00000000, 4'b0000, 1'b1, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
